lcd_value_formatter: RTL and testbench

//  Upstream feeder for the 2x16 LCD text sender. Takes a 16-bit unsigned value, converts it to

---
 rtl/lcd_value_formatter_pkg.sv | 30 +++
 rtl/lcd_value_formatter_if.sv | 23 ++
 rtl/lcd_value_formatter_bcd.sv | 53 +++++
 rtl/lcd_value_formatter.sv | 149 ++++++++++++++
 tb/tb_lcd_value_formatter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/lcd_value_formatter_pkg.sv
// Shared types and helpers for the LCD value formatter: line geometry, FSM states
// and ASCII conversion functions.
package lcd_pkg;

  localparam int         LINE_LENGTH = 16;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    FORMAT,
    SEND,
    WAIT_DONE,
    HOLDOFF
  } fmt_state_t;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

  // A-F map to 8'h41..8'h46, i.e. 8'h37 + nibble.
  function automatic logic [7:0] nibble_to_hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_ZERO + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/lcd_value_formatter_if.sv
// Value-in / text-out signal bundle between the value producer, the formatter and the
// LCD text sender.
interface lcd_value_formatter_if;

  logic [15:0]  value;
  logic         update;
  logic         sendingDone;
  logic         sendText;
  logic [128:1] line1;
  logic [128:1] line2;
  logic         busy;

  modport slave (
    input  value, update, sendingDone,
    output sendText, line1, line2, busy
  );

  modport master (
    output value, update, sendingDone,
    input  sendText, line1, line2, busy
  );

endinterface

// File: rtl/lcd_value_formatter_bcd.sv
// Sequential 16-bit binary to 5-digit BCD converter (double-dabble, one shift per cycle).
// done is a combinational pulse in the cycle whose closing edge performs the last shift.
module bin_to_bcd16
  import lcd_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] shift_reg;
  logic [19:0] bcd_reg;
  logic [4:0]  count_reg;
  logic        running_reg;
  logic [19:0] adjusted;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adjust
      assign adjusted[gi*4+3 -: 4] = (bcd_reg[gi*4+3 -: 4] >= 4'd5)
                                     ? bcd_reg[gi*4+3 -: 4] + 4'd3
                                     : bcd_reg[gi*4+3 -: 4];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shift_reg   <= '0;
      bcd_reg     <= '0;
      count_reg   <= '0;
      running_reg <= 1'b0;
    end else if (start) begin
      shift_reg   <= bin;
      bcd_reg     <= '0;
      count_reg   <= 5'd16;
      running_reg <= 1'b1;
    end else if (running_reg) begin
      bcd_reg   <= {adjusted[18:0], shift_reg[15]};
      shift_reg <= {shift_reg[14:0], 1'b0};
      count_reg <= count_reg - 5'd1;
      if (count_reg == 5'd1) begin
        running_reg <= 1'b0;
      end
    end
  end

  assign done = running_reg && (count_reg == 5'd1);
  assign bcd  = bcd_reg;

endmodule

// File: rtl/lcd_value_formatter.sv
// Converts a 16-bit value to right-aligned decimal text for a 2x16 LCD and hands it to the
// text sender, coalescing updates while busy. Optional macro LCD_HEX_LINE_EN adds a hex field.
module lcd_value_formatter
  import lcd_pkg::*;
#(
  parameter logic [128:1] TITLE          = "VALUE           ",
  parameter int           HOLDOFF_CYCLES = 5_000_000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  lcd_value_formatter_if.slave bus
);

  localparam int HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    HOLD_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
  localparam logic [128:1] BLANK_LINE = {LINE_LENGTH{ASCII_SPACE}};

  fmt_state_t        state_reg, state_next;
  logic [15:0]       shadow_reg;
  logic              pending_reg;
  logic [128:1]      line1_reg, line2_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;

  logic              conv_start, conv_done;
  logic [15:0]       conv_bin;
  logic [19:0]       conv_bcd;
  logic [7:0]        char_fmt [LINE_LENGTH];
  logic [128:1]      line2_fmt;

  // A fresh update in IDLE takes priority over the coalesced shadow value.
  assign conv_start = (state_reg == IDLE) && (bus.update || pending_reg);
  assign conv_bin   = bus.update ? bus.value : shadow_reg;

  bin_to_bcd16 u_bcd (
    .CLK   (CLK),
    .RESET (RESET),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (conv_start) state_next = CONVERT;
      CONVERT:   if (conv_done) state_next = FORMAT;
      FORMAT:    state_next = SEND;
      SEND:      state_next = WAIT_DONE;
      WAIT_DONE: if (bus.sendingDone) state_next = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
      HOLDOFF:   if (hold_cnt_reg == '0) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.sendText = (state_reg == SEND);
    bus.busy     = (state_reg != IDLE);
  end

  assign bus.line1 = line1_reg;
  assign bus.line2 = line2_reg;

`ifdef LCD_HEX_LINE_EN
  logic [15:0] operand_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      operand_reg <= '0;
    end else if (conv_start) begin
      operand_reg <= conv_bin;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow_reg   <= '0;
      pending_reg  <= 1'b0;
      line1_reg    <= TITLE;
      line2_reg    <= BLANK_LINE;
      hold_cnt_reg <= '0;
    end else begin
      if (state_reg == IDLE) begin
        if (conv_start) pending_reg <= 1'b0;
      end else if (bus.update) begin
        shadow_reg  <= bus.value;
        pending_reg <= 1'b1;
      end

      if (state_reg == FORMAT) begin
        line1_reg <= TITLE;
        line2_reg <= line2_fmt;
      end

      if ((state_reg == WAIT_DONE) && bus.sendingDone) begin
        hold_cnt_reg <= HOLD_LOAD;
      end else if ((state_reg == HOLDOFF) && (hold_cnt_reg != '0)) begin
        hold_cnt_reg <= hold_cnt_reg - 1'b1;
      end
    end
  end

  // Decimal field: char gi shows BCD digit (4-gi); it is blanked when it and every more
  // significant digit are zero, except the ones digit which always shows.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_dec
      logic [3:0] dig;
      assign dig = conv_bcd[4*(4-gi)+3 -: 4];
      if (gi < 4) begin : g_blankable
        assign char_fmt[gi] = (conv_bcd[19 -: 4*(gi+1)] == '0) ? ASCII_SPACE
                                                                : digit_to_ascii(dig);
      end else begin : g_ones
        assign char_fmt[gi] = digit_to_ascii(dig);
      end
    end

    for (gi = 5; gi < LINE_LENGTH; gi++) begin : g_tail
`ifdef LCD_HEX_LINE_EN
      if (gi == 8) begin : g_hex_0
        assign char_fmt[gi] = ASCII_ZERO;
      end else if (gi == 9) begin : g_hex_x
        assign char_fmt[gi] = 8'h78;
      end else if ((gi >= 10) && (gi <= 13)) begin : g_hex_nib
        assign char_fmt[gi] = nibble_to_hex_ascii(operand_reg[15-4*(gi-10) -: 4]);
      end else begin : g_pad
        assign char_fmt[gi] = ASCII_SPACE;
      end
`else
      assign char_fmt[gi] = ASCII_SPACE;
`endif
    end

    for (gi = 0; gi < LINE_LENGTH; gi++) begin : g_pack
      assign line2_fmt[128-8*gi -: 8] = char_fmt[gi];
    end
  endgenerate

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Directed bench for lcd_value_formatter: decimal vectors table plus hand-written
// coalescing, stray-done and mid-operation reset sequences.
module tb_lcd_value_formatter;

  localparam int           HOLD      = 20;
  localparam logic [128:1] EXP_TITLE = "VALUE           ";
  localparam logic [128:1] EXP_BLANK = "                ";

  typedef struct {
    logic [15:0]  value;
    logic [128:1] dec_line;
    logic [128:1] hex_line;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs [8];

  always #5 CLK = ~CLK;

  lcd_value_formatter_if bus ();

  lcd_value_formatter #(
    .TITLE          (EXP_TITLE),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  function automatic logic [128:1] pick(input logic [128:1] dec_l, input logic [128:1] hex_l);
`ifdef LCD_HEX_LINE_EN
    return hex_l;
`else
    return dec_l;
`endif
  endfunction

  task automatic check(input string name, input logic [128:1] act, input logic [128:1] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_update(input logic [15:0] v);
    @(negedge CLK);
    bus.value  = v;
    bus.update = 1'b1;
    @(posedge CLK);
    #1 bus.update = 1'b0;
  endtask

  task automatic wait_send(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge CLK);
      #1;
      if (bus.sendText) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic done_and_holdoff(input int gap, output int cyc);
    repeat (gap) @(posedge CLK);
    @(negedge CLK);
    bus.sendingDone = 1'b1;
    @(posedge CLK);
    #1 bus.sendingDone = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge CLK);
      #1;
      if (!bus.busy) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic count_sends(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      #1;
      if (bus.sendText) n++;
    end
  endtask

  initial begin
    int lat, hcyc, nsend;

    vecs[0] = '{16'd12345, "12345           ", "12345   0x3039  "};
    vecs[1] = '{16'd0,     "    0           ", "    0   0x0000  "};
    vecs[2] = '{16'd65535, "65535           ", "65535   0xFFFF  "};
    vecs[3] = '{16'd907,   "  907           ", "  907   0x038B  "};
    vecs[4] = '{16'd48879, "48879           ", "48879   0xBEEF  "};
    vecs[5] = '{16'd10,    "   10           ", "   10   0x000A  "};
    vecs[6] = '{16'd100,   "  100           ", "  100   0x0064  "};
    vecs[7] = '{16'd9999,  " 9999           ", " 9999   0x270F  "};

    bus.value       = '0;
    bus.update      = 1'b0;
    bus.sendingDone = 1'b0;
    RESET           = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_sendText", 128'(bus.sendText), 128'(0));
    check("reset_busy",     128'(bus.busy),     128'(0));
    check("reset_line1",    bus.line1,          EXP_TITLE);
    check("reset_line2",    bus.line2,          EXP_BLANK);
    $display("reset: busy=%0b sendText=%0b line2=\"%s\"", bus.busy, bus.sendText, bus.line2);
    @(negedge CLK);
    RESET = 1'b0;

    for (int v = 0; v < 8; v++) begin
      do_update(vecs[v].value);
      wait_send(lat);
      check($sformatf("v%0d_latency", v), 128'(lat), 128'(17));
      check($sformatf("v%0d_line2", v),   bus.line2, pick(vecs[v].dec_line, vecs[v].hex_line));
      check($sformatf("v%0d_line1", v),   bus.line1, EXP_TITLE);
      $display("vec %0d: value=%0d latency=%0d line2=\"%s\"", v, vecs[v].value, lat, bus.line2);
      @(posedge CLK);
      #1;
      check($sformatf("v%0d_single_pulse", v), 128'(bus.sendText), 128'(0));
      done_and_holdoff((v == 0) ? 100 : 5, hcyc);
      check($sformatf("v%0d_holdoff", v), 128'(hcyc), 128'(HOLD));
    end

    // sendingDone during CONVERT must be ignored; WAIT_DONE then waits for the real one.
    do_update(16'd555);
    @(negedge CLK);
    bus.sendingDone = 1'b1;
    @(posedge CLK);
    #1 bus.sendingDone = 1'b0;
    wait_send(lat);
    check("stray_done_latency", 128'(lat), 128'(16));
    repeat (30) @(posedge CLK);
    #1;
    check("stray_done_still_busy", 128'(bus.busy), 128'(1));
    $display("stray done: latency=%0d busy=%0b line2=\"%s\"", lat, bus.busy, bus.line2);
    done_and_holdoff(0, hcyc);
    check("stray_done_holdoff", 128'(hcyc), 128'(HOLD));

    // Two updates during WAIT_DONE coalesce into one send of the last value.
    do_update(16'd500);
    wait_send(lat);
    check("coal_first_latency", 128'(lat), 128'(17));
    do_update(16'd7);
    do_update(16'd42);
    done_and_holdoff(5, hcyc);
    check("coal_holdoff", 128'(hcyc), 128'(HOLD));
    wait_send(lat);
    check("coal_second_latency", 128'(lat), 128'(18));
    check("coal_line2", bus.line2, pick("   42           ", "   42   0x002A  "));
    $display("coalesce: latency=%0d line2=\"%s\"", lat, bus.line2);
    done_and_holdoff(5, hcyc);
    count_sends(60, nsend);
    check("coal_no_extra_send", 128'(nsend), 128'(0));
    check("coal_idle", 128'(bus.busy), 128'(0));

    // Reset during WAIT_DONE with a pending value drops everything.
    do_update(16'd321);
    wait_send(lat);
    check("rst_latency", 128'(lat), 128'(17));
    do_update(16'd9);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_busy",     128'(bus.busy),     128'(0));
    check("rst_sendText", 128'(bus.sendText), 128'(0));
    check("rst_line2",    bus.line2,          EXP_BLANK);
    check("rst_line1",    bus.line1,          EXP_TITLE);
    @(negedge CLK);
    RESET = 1'b0;
    count_sends(60, nsend);
    check("rst_no_send", 128'(nsend), 128'(0));
    check("rst_idle",    128'(bus.busy), 128'(0));
    $display("mid-op reset: sends after reset=%0d busy=%0b", nsend, bus.busy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
